// File: rtl/demux_pkg.sv
// Shared types and constants for the demux scheduler.
// FSM encodings, channel count and distribution modes.
package demux_pkg;

  localparam int N  = 8;
  localparam int SW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

endpackage

// File: rtl/demux_scheduler_rr_next.sv
// Next enabled channel strictly above a pointer, wrapping 7->0.
// Returns the pointer itself when no other channel is enabled.
module rr_next
  import demux_pkg::*;
(
  input  logic [SW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [SW-1:0] o_next
);

  logic [SW-1:0] w_idx;

  always_comb begin
    o_next = i_ptr;
    w_idx  = i_ptr;
    // descending scan so the nearest enabled index wins
    for (int k = N-1; k >= 1; k--) begin
      w_idx = i_ptr + SW'(k);
      if (i_mask[w_idx]) o_next = w_idx;
    end
  end

endmodule

// File: rtl/demux_scheduler.sv
// 1-to-8 scheduled demultiplexer with per-channel output slots.
// Round-robin or addressed distribution, valid/ready on both sides.
module demux_scheduler
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   Din,
  input  logic           Din_valid,
  output logic           Din_ready,
  input  logic           Mode,
  input  logic [SW-1:0]  Addr,
  input  logic [N-1:0]   En,
  output logic [N*W-1:0] Y,
  output logic [N-1:0]   Y_valid,
  input  logic [N-1:0]   Y_ready,
  output logic [SW-1:0]  S,
  output logic [1:0]     State
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SW-1:0]  r_ptr;
  logic [SW-1:0]  w_ptr_nxt;
  logic [SW-1:0]  w_tgt;
  logic           w_en_ok;
  logic           w_slot_ok;
  logic           w_xfer;
  logic           w_any_en;
  logic           w_ptr_mv;
  logic [N-1:0]   w_we;
  logic [N-1:0]   r_yv;
  logic [N*W-1:0] r_y;

  assign w_tgt     = (Mode == MODE_ADDR) ? Addr : r_ptr;
  assign w_en_ok   = En[w_tgt];
  assign w_slot_ok = !r_yv[w_tgt] || Y_ready[w_tgt];
  assign w_any_en  = |En;
  assign w_xfer    = Din_valid && Din_ready;

  // one-hot slot write enable, gated by the transfer
  assign w_we = w_xfer ? (N'(1) << w_tgt) : '0;

  rr_next u_rr (
    .i_ptr  (r_ptr),
    .i_mask (En),
    .o_next (w_ptr_nxt)
  );

  assign w_ptr_mv = w_any_en &&
    ((w_xfer && Mode == MODE_RR) || !En[r_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = RUN;
      RUN: begin
        if (Din_valid && w_en_ok && !w_slot_ok)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_xfer || !Din_valid)
          w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!w_any_en) w_state_nxt = IDLE;
  end

  always_comb begin
    Din_ready = (r_state == RUN || r_state == WAIT)
             && w_en_ok && w_slot_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_ptr_mv) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_yv <= '0;
      r_y  <= '0;
    end else begin
      r_yv <= (r_yv & ~Y_ready) | w_we;
      for (int i = 0; i < N; i++) begin
        if (w_we[i]) r_y[i*W +: W] <= Din;
      end
    end
  end

  assign Y       = r_y;
  assign Y_valid = r_yv;
  assign S       = w_tgt;
  assign State   = r_state;

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter W, default 8: data word width in bits.
REQ-002 Parameter N, fixed at 8: number of output channels; the select width SW is 3.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port Din, input, W bits: input data word.
REQ-007 Port Din_valid, input, 1 bit: Din is valid.
REQ-008 Port Din_ready, output, 1 bit: the block accepts Din this cycle.
REQ-009 Port Mode, input, 1 bit: 0 = round-robin distribution; 1 = addressed distribution.
REQ-010 Port Addr, input, 3 bits: target channel when Mode=1; sampled with Din.
REQ-011 Port En, input, 8 bits: channel enable mask.
REQ-012 Port Y, output, 8*W bits: per-channel output data registers; channel i occupies bits [i*W+W-1 : i*W].
REQ-013 Port Y_valid, output, 8 bits: per-channel output-slot-full flags.
REQ-014 Port Y_ready, input, 8 bits: per-channel consumer ready.
REQ-015 Port S, output, 3 bits: current select, i.e. the target channel of the next transfer.
REQ-016 Port State, output, 2 bits: FSM state, encoded IDLE=0, RUN=1, WAIT=2.

Function
REQ-017 A transfer SHALL occur when Din_valid and Din_ready are both 1 at a rising clk edge.
REQ-018 In Mode=0, the target SHALL be the pointer register, which is always held on an enabled channel when En≠0.
REQ-019 In Mode=1, the target SHALL be Addr; if En[Addr]=0, Din_ready SHALL be 0.
REQ-020 Din_ready SHALL be 1 only when all of the following hold:
- State is RUN or WAIT;
- the target is enabled;
- slot[target] is empty, or is drained this cycle (Y_valid and Y_ready both 1 for that channel).
REQ-021 Din_ready SHALL be combinational from the current state and inputs; it SHALL NOT depend on Din_valid.
REQ-022 On a transfer, the block SHALL load Din into Y[target] and set Y_valid[target] at the next edge (latency 1 cycle).
REQ-023 Y_valid[i] SHALL clear on the edge where Y_valid[i] and Y_ready[i] are both 1, unless a simultaneous transfer to channel i occurs; in that case Y_valid[i] stays 1 and Y[i] takes the new Din.
REQ-024 Y[i] SHALL hold its value whenever no transfer to channel i occurs.
REQ-025 In Mode=0, after each transfer the pointer SHALL advance to the next enabled channel above target, wrapping 7→0; if target is the only enabled channel, the pointer stays.
REQ-026 The pointer SHALL NOT move in Mode=1 or when no transfer occurs.
REQ-027 If En clears the channel the pointer is on, the pointer SHALL move to the next enabled channel at the following edge without a transfer.
REQ-028 S SHALL equal the target (pointer in Mode=0, Addr in Mode=1).
REQ-029 FSM transitions:
- IDLE→RUN when En≠0.
- RUN→WAIT when Din_valid=1 and Din_ready=0 because the target slot is full.
- WAIT→RUN on a transfer or when Din_valid=0.
- Any state→IDLE when En=0.
REQ-030 In IDLE, Din_ready SHALL be 0 and output slots SHALL still drain.
REQ-031 Changes to Mode SHALL take effect on the next cycle; slot contents are unaffected.

Reset
REQ-032 While rst_n=0, the block SHALL force: State=IDLE, pointer=0, Y_valid=0, Y=0, Din_ready=0.
REQ-033 Reset asserted mid-operation SHALL discard all slot contents; no partial transfer completes.
REQ-034 The first transfer after reset release SHALL be possible no earlier than the second rising edge (IDLE→RUN, then accept).

Structure
REQ-035 A shared package demux_pkg SHALL hold the FSM state typedef and encodings, the N and SW constants, and the Mode encodings.
REQ-036 One sub-module, rr_next (3-bit pointer plus 8-bit mask → next enabled index with wrap), SHALL be instantiated for REQ-025 and REQ-027.
REQ-037 The datapath select decode SHALL reuse the existing demux_1x8 structure: a one-hot write enable generated from S gated by the transfer signal.

Verification
REQ-038 Round-robin: Mode=0, En=8'hFF, Y_ready=8'hFF, 8 words 0x10..0x17 → each appears on Y[0..7] in order, 1-cycle latency each, S then wraps to 0.
REQ-039 Sparse mask: Mode=0, En=8'b1010_0100, 4 words → channel order 2, 5, 7, 2.
REQ-040 Backpressure: Y_ready[3]=0, Mode=1, Addr=3, 2 words → first is held in Y[3], Din_ready=0, State=WAIT; raise Y_ready[3] → second word is accepted on the same edge the first drains, and Y_valid[3] stays 1.
REQ-041 Disabled address: Mode=1, Addr=6, En[6]=0 → Din_ready=0 indefinitely and no slot changes.
REQ-042 Reset mid-stream: assert rst_n=0 with 3 slots full → Y_valid=0 immediately (asynchronously), S=0, State=IDLE after release.
REQ-043 Enable drop: clear En while State=RUN → State=IDLE next edge, Din_ready=0, and full slots drain normally.
